// File: rtl/mem_io_bridge_if.sv
// rtl/mem_io_bridge_if.sv - mem_mesh io bus plus host in/out streams bundled for mem_io_bridge
interface mem_io_bridge_if #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0]            io_active_out;
  logic [PORTS*DATA_WIDTH-1:0] io_data_out;
  logic [PORTS-1:0]            io_active_in;
  logic [PORTS*DATA_WIDTH-1:0] io_data_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [PORT_W-1:0]           out_port;
  logic [DATA_WIDTH-1:0]       out_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [PORT_W-1:0]           in_port;
  logic [DATA_WIDTH-1:0]       in_data;

  modport slave (
    input  io_active_out, io_data_out, out_ready, in_valid, in_port, in_data,
    output io_active_in, io_data_in, out_valid, out_port, out_data, in_ready
  );

  modport master (
    output io_active_out, io_data_out, out_ready, in_valid, in_port, in_data,
    input  io_active_in, io_data_in, out_valid, out_port, out_data, in_ready
  );
endinterface

// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - mem_mesh io bus <-> host stream bridge with round-robin outbound drain
// Optional sticky overflow flags under MEM_IO_BRIDGE_OVF_EN.
module mem_io_bridge #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MEM_IO_BRIDGE_OVF_EN
  output logic [PORTS-1:0] ovf,
  input  logic             ovf_clr,
`endif
  mem_io_bridge_if.slave   bus
);
  localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0]                 pending_q, pending_d;
  logic [PORTS-1:0][DATA_WIDTH-1:0] hold_q, hold_d;
  logic [PORT_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic                             out_valid_q, out_valid_d;
  logic [PORT_W-1:0]                out_port_q, out_port_d;
  logic [DATA_WIDTH-1:0]            out_data_q, out_data_d;
  logic                             in_ready_q, in_ready_d;
  logic [PORTS-1:0]                 io_active_in_q, io_active_in_d;
  logic [PORTS*DATA_WIDTH-1:0]      io_data_in_q, io_data_in_d;
`ifdef MEM_IO_BRIDGE_OVF_EN
  logic [PORTS-1:0]                 ovf_q, ovf_d;
`endif

  logic              slot_free;
  logic              pick_found;
  logic              drain;
  logic              in_accept;
  logic [PORT_W-1:0] pick;
  logic [PORT_W-1:0] scan_idx;

  always_comb begin
    pending_d      = pending_q;
    hold_d         = hold_q;
    rr_ptr_d       = rr_ptr_q;
    out_valid_d    = out_valid_q;
    out_port_d     = out_port_q;
    out_data_d     = out_data_q;
    in_ready_d     = 1'b1;
    io_active_in_d = '0;
    io_data_in_d   = '0;
`ifdef MEM_IO_BRIDGE_OVF_EN
    ovf_d          = ovf_clr ? '0 : ovf_q;
`endif

    slot_free  = !out_valid_q || bus.out_ready;
    pick_found = 1'b0;
    pick       = '0;
    scan_idx   = '0;
    for (int k = 0; k < PORTS; k++) begin
      scan_idx = PORT_W'((int'(rr_ptr_q) + k) % PORTS);
      if (!pick_found && pending_q[scan_idx]) begin
        pick_found = 1'b1;
        pick       = scan_idx;
      end
    end
    drain = slot_free && pick_found;

    if (slot_free) begin
      out_valid_d = pick_found;
      if (pick_found) begin
        out_port_d      = pick;
        out_data_d      = hold_q[pick];
        pending_d[pick] = 1'b0;
        rr_ptr_d        = PORT_W'((int'(pick) + 1) % PORTS);
      end
    end

    // Capture after the drain so a same-edge write re-arms pending with the new word.
    for (int p = 0; p < PORTS; p++) begin
      if (bus.io_active_out[p]) begin
`ifdef MEM_IO_BRIDGE_OVF_EN
        if (pending_q[p] && !(drain && (pick == PORT_W'(p)))) begin
          ovf_d[p] = 1'b1;
        end
`endif
        hold_d[p]    = bus.io_data_out[p*DATA_WIDTH +: DATA_WIDTH];
        pending_d[p] = 1'b1;
      end
    end

    // Out-of-range port indices match no slot and are silently consumed.
    in_accept = bus.in_valid && in_ready_q;
    for (int p = 0; p < PORTS; p++) begin
      if (in_accept && (bus.in_port == PORT_W'(p))) begin
        io_active_in_d[p]                         = 1'b1;
        io_data_in_d[p*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
      end
    end
`ifdef MEM_IO_BRIDGE_OVF_EN
    if (in_accept && (int'(bus.in_port) >= PORTS)) begin
      ovf_d[PORTS-1] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q      <= '0;
      hold_q         <= '0;
      rr_ptr_q       <= '0;
      out_valid_q    <= 1'b0;
      out_port_q     <= '0;
      out_data_q     <= '0;
      in_ready_q     <= 1'b0;
      io_active_in_q <= '0;
      io_data_in_q   <= '0;
`ifdef MEM_IO_BRIDGE_OVF_EN
      ovf_q          <= '0;
`endif
    end else begin
      pending_q      <= pending_d;
      hold_q         <= hold_d;
      rr_ptr_q       <= rr_ptr_d;
      out_valid_q    <= out_valid_d;
      out_port_q     <= out_port_d;
      out_data_q     <= out_data_d;
      in_ready_q     <= in_ready_d;
      io_active_in_q <= io_active_in_d;
      io_data_in_q   <= io_data_in_d;
`ifdef MEM_IO_BRIDGE_OVF_EN
      ovf_q          <= ovf_d;
`endif
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_port     = out_port_q;
  assign bus.out_data     = out_data_q;
  assign bus.in_ready     = in_ready_q;
  assign bus.io_active_in = io_active_in_q;
  assign bus.io_data_in   = io_data_in_q;
`ifdef MEM_IO_BRIDGE_OVF_EN
  assign ovf              = ovf_q;
`endif
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - directed bench for mem_io_bridge with a per-cycle reference model
module tb_mem_io_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_io_bridge_if #(.PORTS(4), .DATA_WIDTH(8)) bif ();
  mem_io_bridge_if #(.PORTS(3), .DATA_WIDTH(8)) bif3 ();

`ifdef MEM_IO_BRIDGE_OVF_EN
  logic [3:0] ovf;
  logic [2:0] ovf3;
  logic       ovf_clr = 1'b0;
`endif

  mem_io_bridge #(.PORTS(4), .DATA_WIDTH(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef MEM_IO_BRIDGE_OVF_EN
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
`endif
    .bus     (bif)
  );

  mem_io_bridge #(.PORTS(3), .DATA_WIDTH(8)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef MEM_IO_BRIDGE_OVF_EN
    .ovf     (ovf3),
    .ovf_clr (ovf_clr),
`endif
    .bus     (bif3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec rules on plain arrays, advanced once per rising edge.
  localparam int NP = 4;
  bit         m_valid;
  int         m_port;
  logic [7:0] m_data;
  bit         m_pend [NP];
  logic [7:0] m_hold [NP];
  int         m_rr;
  bit         m_in_ready;
  logic [3:0] m_act_in;
  logic [31:0] m_din;
  logic [3:0] m_ovf;

  task automatic model_step();
    bit free, found;
    int drained, ip;
    if (!rst_n) begin
      m_valid = 0; m_port = 0; m_data = 0; m_rr = 0; m_in_ready = 0;
      m_act_in = 0; m_din = 0; m_ovf = 0;
      for (int i = 0; i < NP; i++) begin m_pend[i] = 0; m_hold[i] = 0; end
      return;
    end
`ifdef MEM_IO_BRIDGE_OVF_EN
    if (ovf_clr) m_ovf = 0;
`endif
    m_act_in = 0; m_din = 0;
    if (bif.in_valid && m_in_ready) begin
      ip = int'(bif.in_port);
      if (ip < NP) begin
        m_act_in[ip] = 1'b1;
        m_din[ip*8 +: 8] = bif.in_data;
      end else begin
        m_ovf[NP-1] = 1'b1;
      end
    end
    m_in_ready = 1;
    free = !m_valid || bif.out_ready;
    drained = -1;
    if (free) begin
      found = 0;
      for (int k = 0; k < NP; k++) begin
        int q;
        q = (m_rr + k) % NP;
        if (!found && m_pend[q]) begin
          found = 1; m_port = q; m_data = m_hold[q];
          m_pend[q] = 0; m_rr = (q + 1) % NP; drained = q;
        end
      end
      m_valid = found;
    end
    for (int p = 0; p < NP; p++) begin
      if (bif.io_active_out[p]) begin
        if (m_pend[p] && p != drained) m_ovf[p] = 1'b1;
        m_hold[p] = bif.io_data_out[p*8 +: 8];
        m_pend[p] = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("model_out_valid", bif.out_valid, m_valid);
    if (m_valid) begin
      chk("model_out_port", bif.out_port, m_port);
      chk("model_out_data", bif.out_data, m_data);
    end
    chk("model_in_ready", bif.in_ready, m_in_ready);
    chk("model_io_active_in", bif.io_active_in, m_act_in);
    chk("model_io_data_in", bif.io_data_in, m_din);
`ifdef MEM_IO_BRIDGE_OVF_EN
    chk("model_ovf", ovf, m_ovf);
`endif
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic v, input logic [1:0] p, input logic [7:0] d);
    chk({name, "_valid"}, bif.out_valid, v);
    if (v) begin
      chk({name, "_port"}, bif.out_port, p);
      chk({name, "_data"}, bif.out_data, d);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    bif.io_active_out = 0; bif.io_data_out = 0; bif.out_ready = 0;
    bif.in_valid = 0; bif.in_port = 0; bif.in_data = 0;
    bif3.io_active_out = 0; bif3.io_data_out = 0; bif3.out_ready = 0;
    bif3.in_valid = 0; bif3.in_port = 0; bif3.in_data = 0;
`ifdef MEM_IO_BRIDGE_OVF_EN
    ovf_clr = 0;
`endif
    cyc(); cyc();
    rst_n = 1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("reset_in_ready", bif.in_ready, 1'b1);
    chk("reset_io_active_in", bif.io_active_in, 4'b0000);
    expect_out("reset", 1'b0, 2'd0, 8'h00);

    // Single word: sampled at E0, visible after E1, gone after E2.
    bif.out_ready = 1;
    bif.io_active_out = 4'b0100; bif.io_data_out = 32'h00A5_0000;
    cyc(); bif.io_active_out = 0;
    expect_out("t1_e0", 1'b0, 2'd0, 8'h00);
    cyc(); expect_out("t1_word", 1'b1, 2'd2, 8'hA5);
    cyc(); expect_out("t1_idle", 1'b0, 2'd0, 8'h00);

    // All four ports at once drain 0..3 back to back.
    do_reset();
    bif.out_ready = 1;
    bif.io_active_out = 4'b1111; bif.io_data_out = 32'h1312_1110;
    cyc(); bif.io_active_out = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); expect_out("t2_word", 1'b1, 2'(i), 8'h10 + 8'(i));
    end
    cyc(); expect_out("t2_idle", 1'b0, 2'd0, 8'h00);

    // Stalled slot: port1 is written twice, latest value wins.
    do_reset();
    bif.io_active_out = 4'b0001; bif.io_data_out = 32'h0000_0077;
    cyc(); bif.io_active_out = 0;
    cyc(); expect_out("t3_slot", 1'b1, 2'd0, 8'h77);
    bif.io_active_out = 4'b0010; bif.io_data_out = 32'h0000_0100;
    cyc(); bif.io_active_out = 0;
    cyc(); bif.io_active_out = 4'b0010; bif.io_data_out = 32'h0000_0200;
    cyc(); bif.io_active_out = 0;
    expect_out("t3_stable", 1'b1, 2'd0, 8'h77);
    cyc(); cyc(); cyc();
`ifdef MEM_IO_BRIDGE_OVF_EN
    chk("t3_ovf_set", ovf, 4'b0010);
`endif
    bif.out_ready = 1;
    cyc(); expect_out("t3_latest", 1'b1, 2'd1, 8'h02);
    cyc(); expect_out("t3_idle", 1'b0, 2'd0, 8'h00);
`ifdef MEM_IO_BRIDGE_OVF_EN
    chk("t3_ovf_sticky", ovf, 4'b0010);
    ovf_clr = 1;
    cyc(); ovf_clr = 0;
    chk("t3_ovf_clr", ovf, 4'b0000);
`endif

    // Drain of port3 coincides with a new port3 write.
    do_reset();
    bif.io_active_out = 4'b0001; bif.io_data_out = 32'h0000_0055;
    cyc(); bif.io_active_out = 4'b1000; bif.io_data_out = 32'hAA00_0000;
    cyc(); bif.io_active_out = 0;
    expect_out("t4_slot", 1'b1, 2'd0, 8'h55);
    bif.out_ready = 1;
    bif.io_active_out = 4'b1000; bif.io_data_out = 32'hBB00_0000;
    cyc(); bif.io_active_out = 0;
    expect_out("t4_old", 1'b1, 2'd3, 8'hAA);
    cyc(); expect_out("t4_new", 1'b1, 2'd3, 8'hBB);
    cyc(); expect_out("t4_idle", 1'b0, 2'd0, 8'h00);
`ifdef MEM_IO_BRIDGE_OVF_EN
    chk("t4_no_ovf", ovf, 4'b0000);
`endif

    // Inbound pulses, with a simultaneous outbound write on the same port.
    do_reset();
    bif.out_ready = 1;
    bif.in_valid = 1; bif.in_port = 2'd1; bif.in_data = 8'h3C;
    bif.io_active_out = 4'b0010; bif.io_data_out = 32'h0000_4400;
    cyc(); bif.in_valid = 0; bif.io_active_out = 0;
    chk("t5_act", bif.io_active_in, 4'b0010);
    chk("t5_data", bif.io_data_in, 32'h0000_3C00);
    cyc();
    chk("t5_act_end", bif.io_active_in, 4'b0000);
    chk("t5_data_end", bif.io_data_in, 32'h0000_0000);
    expect_out("t5_out", 1'b1, 2'd1, 8'h44);
    bif.in_valid = 1; bif.in_port = 2'd0; bif.in_data = 8'h5A;
    cyc(); bif.in_port = 2'd3; bif.in_data = 8'hC3;
    chk("t5_b2b0_act", bif.io_active_in, 4'b0001);
    chk("t5_b2b0_data", bif.io_data_in, 32'h0000_005A);
    cyc(); bif.in_valid = 0;
    chk("t5_b2b1_act", bif.io_active_in, 4'b1000);
    chk("t5_b2b1_data", bif.io_data_in, 32'hC300_0000);
    cyc(); chk("t5_b2b_end", bif.io_active_in, 4'b0000);

    // Three-port instance: index 3 is out of range and is dropped.
    bif3.in_valid = 1; bif3.in_port = 2'd3; bif3.in_data = 8'h99;
    cyc(); bif3.in_valid = 0;
    chk("t5_bad_act", bif3.io_active_in, 3'b000);
    chk("t5_bad_data", bif3.io_data_in, 24'h000000);
    chk("t5_bad_ready", bif3.in_ready, 1'b1);
`ifdef MEM_IO_BRIDGE_OVF_EN
    chk("t5_bad_ovf", ovf3, 3'b100);
`endif
    bif3.in_valid = 1; bif3.in_port = 2'd2; bif3.in_data = 8'h66;
    cyc(); bif3.in_valid = 0;
    chk("t5_p2_act", bif3.io_active_in, 3'b100);
    chk("t5_p2_data", bif3.io_data_in, 24'h660000);

    // Reset while a word is presented and two more are pending.
    do_reset();
    bif.io_active_out = 4'b0111; bif.io_data_out = 32'h0033_3231;
    cyc(); bif.io_active_out = 0;
    cyc(); expect_out("t6_slot", 1'b1, 2'd0, 8'h31);
    rst_n = 0;
    cyc();
    chk("t6_rst_valid", bif.out_valid, 1'b0);
    chk("t6_rst_port", bif.out_port, 2'd0);
    chk("t6_rst_data", bif.out_data, 8'h00);
    chk("t6_rst_ready", bif.in_ready, 1'b0);
    chk("t6_rst_act", bif.io_active_in, 4'b0000);
    rst_n = 1; bif.out_ready = 1;
    cyc(); chk("t6_in_ready", bif.in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(); expect_out("t6_no_stale", 1'b0, 2'd0, 8'h00);
    end

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
